// File: rtl/cache_define.sv
// Shared command codes, widths, trace record and FSM state
// for the LLC command issuer.
package cache_define;

  localparam int CMD_W  = 5;
  localparam int ADDR_W = 32;

  typedef enum logic [CMD_W-1:0] {
    CMD_READ     = 5'd0,
    CMD_WRITE    = 5'd1,
    CMD_IFETCH   = 5'd2,
    CMD_SNP_INV  = 5'd3,
    CMD_SNP_RD   = 5'd4,
    CMD_SNP_WR   = 5'd5,
    CMD_SNP_RWIM = 5'd6,
    CMD_CLEAR    = 5'd8,
    CMD_PRINT    = 5'd9
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_PRINT
  } state_e;

  typedef enum logic [1:0] {
    CLS_ISSUE,
    CLS_PRINT,
    CLS_ERR
  } cmd_cls_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
  } trace_t;

  localparam int TRACE_W = $bits(trace_t);

  function automatic cmd_cls_e cmd_class(
    input logic [CMD_W-1:0] c
  );
    cmd_cls_e cls;
    unique case (1'b1)
      (c == CMD_PRINT):
        cls = CLS_PRINT;
      (c <= CMD_SNP_RWIM),
      (c == CMD_CLEAR):
        cls = CLS_ISSUE;
      default:
        cls = CLS_ERR;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/llc_cmd_issuer_fifo.sv
// Trace FIFO: registered storage, wrap-bit pointers,
// no bypass; push and pop may share a cycle.
module llc_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)
        r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW])
                && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/llc_cmd_issuer.sv
// LLC command issuer: drains the trace FIFO, issues requests,
// tracks hit/miss responses and keeps saturating statistics.
module llc_cmd_issuer
  import cache_define::*;
#(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_valid,
  output logic              trace_ready,
  input  logic [CMD_W-1:0]  trace_cmd,
  input  logic [ADDR_W-1:0] trace_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [CMD_W-1:0]  req_cmd,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic              rsp_hit,
  output logic              stats_valid,
  output logic [CNT_W-1:0]  read_cnt,
  output logic [CNT_W-1:0]  write_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  state_e              r_state;
  logic [CMD_W-1:0]    r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_req_valid;
  logic                r_stats_valid;
  logic [TW-1:0]       r_tmo;
  logic [CNT_W-1:0]    r_read_cnt;
  logic [CNT_W-1:0]    r_write_cnt;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;
  logic [CNT_W-1:0]    r_err_cnt;

  trace_t              w_wdata;
  trace_t              w_head;
  logic [TRACE_W-1:0]  w_rdata;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  cmd_cls_e            w_cls;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_wdata = '{cmd: trace_cmd, addr: trace_addr};
  assign w_head  = trace_t'(w_rdata);
  assign w_pop   = (r_state == ST_IDLE) && !w_empty;
  assign w_cls   = cmd_class(w_head.cmd);

  llc_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (TRACE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (trace_valid),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_addr        <= '0;
      r_req_valid   <= 1'b0;
      r_stats_valid <= 1'b0;
      r_tmo         <= '0;
      r_read_cnt    <= '0;
      r_write_cnt   <= '0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_stats_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cmd  <= w_head.cmd;
            r_addr <= w_head.addr;
            unique case (w_cls)
              CLS_ISSUE: begin
                r_state     <= ST_ISSUE;
                r_req_valid <= 1'b1;
              end
              CLS_PRINT: begin
                r_state       <= ST_PRINT;
                r_stats_valid <= 1'b1;
              end
              default:
                r_err_cnt <= sat_inc(r_err_cnt);
            endcase
          end
        end
        ST_ISSUE: begin
          if (req_ready) begin
            r_req_valid <= 1'b0;
            r_tmo       <= '0;
            r_state     <= ST_IDLE;
            case (r_cmd)
              CMD_READ,
              CMD_IFETCH: begin
                r_read_cnt <= sat_inc(r_read_cnt);
                r_state    <= ST_WAIT_RSP;
              end
              CMD_WRITE: begin
                r_write_cnt <= sat_inc(r_write_cnt);
                r_state     <= ST_WAIT_RSP;
              end
              CMD_CLEAR: begin
                r_read_cnt  <= '0;
                r_write_cnt <= '0;
                r_hit_cnt   <= '0;
                r_miss_cnt  <= '0;
                r_err_cnt   <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_WAIT_RSP: begin
          // a response in the timeout cycle still counts as a response
          if (rsp_valid) begin
            if (rsp_hit)
              r_hit_cnt <= sat_inc(r_hit_cnt);
            else
              r_miss_cnt <= sat_inc(r_miss_cnt);
            r_state <= ST_IDLE;
          end else if (r_tmo == TMO_MAX) begin
            r_err_cnt <= sat_inc(r_err_cnt);
            r_state   <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_PRINT:
          r_state <= ST_IDLE;
        default:
          r_state <= ST_IDLE;
      endcase
    end
  end

  assign trace_ready = !w_full;
  assign req_valid   = r_req_valid;
  assign req_cmd     = r_cmd;
  assign req_addr    = r_addr;
  assign stats_valid = r_stats_valid;
  assign read_cnt    = r_read_cnt;
  assign write_cnt   = r_write_cnt;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;
  assign err_cnt     = r_err_cnt;
  assign busy        = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: doc/llc_cmd_issuer.md
Name: llc_cmd_issuer

Overview:
- Initiator side of the LLC command interface. It buffers trace entries (command + 32-bit address) in a small FIFO and issues them one at a time to the cache over a valid/ready request channel.
- For read, write and instruction-read commands it waits for the cache's hit/miss response, then updates statistics counters.
- Executes the clear (8) and print (9) control commands, and drops undefined commands.

Parameters:
- DEPTH, 8, trace FIFO entries; power of 2, at least 2.
- CNT_W, 32, width of every statistics counter.
- TIMEOUT, 64, cycles to wait for rsp_valid before abandoning a request.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- trace_valid  in  1  trace entry offered.
- trace_ready  out  1  FIFO can accept; equals !full.
- trace_cmd  in  5  trace command code.
- trace_addr  in  32  trace address.
- req_valid  out  1  request to cache valid.
- req_ready  in  1  cache accepts request.
- req_cmd  out  5  command to cache.
- req_addr  out  32  address to cache.
- rsp_valid  in  1  cache response strobe.
- rsp_hit  in  1  1 = hit, 0 = miss; qualified by rsp_valid.
- stats_valid  out  1  one-cycle pulse when a print command executes.
- read_cnt  out  CNT_W  commands 0 and 2 issued.
- write_cnt  out  CNT_W  command 1 issued.
- hit_cnt  out  CNT_W  hit responses.
- miss_cnt  out  CNT_W  miss responses.
- err_cnt  out  CNT_W  undefined commands plus response timeouts.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - FIFO emptied; state IDLE.
  - All outputs 0 except trace_ready = 1.
  - Reset mid-request drops the in-flight request with no counter update.
- FIFO:
  - Push when trace_valid && trace_ready.
  - No push when full, because trace_ready is low.
  - No bypass: an entry pushed into an empty FIFO is poppable in the next cycle.
  - Pointers wrap modulo DEPTH; full/empty are tracked with an extra pointer bit.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- FSM states: IDLE, ISSUE, WAIT_RSP, PRINT.
- IDLE:
  - If the FIFO is not empty, pop the head into a holding register and decode it.
  - cmd 0-6 or 8 -> ISSUE.
  - cmd 9 -> PRINT.
  - cmd 7 or 10-31 -> err_cnt+1, stay in IDLE.
  - At most one pop per cycle.
- ISSUE:
  - req_valid = 1; req_cmd and req_addr driven from the holding register and held stable until req_ready.
  - On handshake (req_valid && req_ready):
    - cmd 0 or 2: read_cnt+1 -> WAIT_RSP.
    - cmd 1: write_cnt+1 -> WAIT_RSP.
    - cmd 3-6 (snoops): -> IDLE; no response is expected.
    - cmd 8: clear all five counters to 0 (this takes priority over any increment in the same cycle) -> IDLE.
  - req_valid drops in the cycle after the handshake; there are no back-to-back requests.
- WAIT_RSP:
  - Timeout counter starts at 0 on entry.
  - rsp_valid -> hit_cnt+1 if rsp_hit, else miss_cnt+1 -> IDLE.
  - Timeout counter reaching TIMEOUT-1 with no rsp_valid -> err_cnt+1 -> IDLE.
  - If rsp_valid arrives in the same cycle as the timeout, the response wins.
- PRINT: stats_valid = 1 for exactly one cycle, counters unchanged -> IDLE.
- rsp_valid while not in WAIT_RSP is ignored.
- All counters saturate at 2^CNT_W-1; they never wrap.
- Latency, empty FIFO and req_ready tied high:
  - push at cycle N;
  - pop at N+1;
  - req_valid at N+2 with handshake;
  - earliest counter update for the response at N+3.

Decomposition:
- Shared package cache_define:
  - command enum: CMD_READ=0, CMD_WRITE=1, CMD_IFETCH=2, CMD_SNP_INV=3, CMD_SNP_RD=4, CMD_SNP_WR=5, CMD_SNP_RWIM=6, CMD_CLEAR=8, CMD_PRINT=9;
  - CMD_W=5, ADDR_W=32;
  - FSM state typedef.
- One sub-module: llc_trace_fifo, parameterised by DEPTH and width 37 (cmd + addr), with push/pop/full/empty.

Test Plan:
- Push {0, 0x1000_0040}, req_ready=1, rsp_valid with rsp_hit=0 two cycles after the handshake:
  - req_valid at cycle N+2 with req_cmd=0, req_addr=0x1000_0040;
  - afterwards read_cnt=1, miss_cnt=1, hit_cnt=0.
- Push 9 entries back-to-back with req_ready=0:
  - trace_ready drops after 8 FIFO pushes plus 1 pop into the holding register;
  - req_addr stays stable;
  - release req_ready: all 9 entries issue in order.
- Push {3, 0x2000_0000}:
  - handshake occurs, FSM returns to IDLE without waiting;
  - a later rsp_valid changes no counter.
- Push {1, A}, then hold rsp_valid low for 64 cycles:
  - err_cnt=1, write_cnt=1, FSM back in IDLE;
  - a late rsp_valid is ignored.
- Sequence {0, A} hit, {7, B}, {9, x}, {8, x}:
  - at the print pulse: hit_cnt=1, read_cnt=1, err_cnt=1;
  - after the clear handshake: all counters = 0.
- Assert rst in WAIT_RSP:
  - next cycle: req_valid=0, busy=0, trace_ready=1, counters=0.
